// File: rtl/mult_sequencer.sv
// Control sequencer for a shift-and-add multiplier: LOAD, then WIDTH EVAL/SHIFT pairs, then DONE.
// Define MULT_SEQUENCER_SIGNED_EN to subtract the final partial product (two's-complement multiplier).
module mult_sequencer #(
    parameter int WIDTH = 8
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     start,
    input  logic                     abort,
    input  logic                     mbit,
    output logic                     busy,
    output logic                     load,
    output logic                     clr_acc,
    output logic                     add_en,
    output logic                     sub_en,
    output logic                     shift_en,
    output logic                     done,
    output logic [$clog2(WIDTH)-1:0] count,
    output logic [2:0]               state
);

    localparam int CW = $clog2(WIDTH);
    localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

    typedef enum logic [2:0] {
        IDLE  = 3'b000,
        LOAD  = 3'b001,
        EVAL  = 3'b010,
        SHIFT = 3'b011,
        DONE  = 3'b100
    } state_t;

    state_t cur;
    state_t nxt;

    always_comb begin
        nxt = cur;
        case (cur)
            IDLE:    if (start && !abort) nxt = LOAD;
            LOAD:    nxt = EVAL;
            EVAL:    nxt = SHIFT;
            SHIFT:   nxt = (count == LAST) ? DONE : EVAL;
            DONE:    nxt = IDLE;
            default: nxt = IDLE;
        endcase
        if (cur != IDLE && abort) nxt = IDLE;
    end

    // Moore outputs are registered from the next state so they line up with the state register.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cur      <= IDLE;
            count    <= '0;
            busy     <= 1'b0;
            load     <= 1'b0;
            clr_acc  <= 1'b0;
            shift_en <= 1'b0;
            done     <= 1'b0;
        end else begin
            cur      <= nxt;
            busy     <= (nxt != IDLE);
            load     <= (nxt == LOAD);
            clr_acc  <= (nxt == LOAD);
            shift_en <= (nxt == SHIFT);
            done     <= (nxt == DONE);
            if (nxt == LOAD || (cur != IDLE && abort))
                count <= '0;
            else if (cur == SHIFT && count != LAST)
                count <= count + CW'(1);
        end
    end

    assign state = cur;

`ifdef MULT_SEQUENCER_SIGNED_EN
    // The multiplier sign bit carries negative weight, so its partial product is subtracted.
    logic is_last;
    assign is_last = (count == LAST);
    assign add_en  = (cur == EVAL) && mbit && !is_last;
    assign sub_en  = (cur == EVAL) && mbit && is_last;
`else
    assign add_en  = (cur == EVAL) && mbit;
    assign sub_en  = 1'b0;
`endif

endmodule

// File: tb/tb_mult_sequencer.sv
// Directed bench for mult_sequencer (WIDTH=8); expectations follow MULT_SEQUENCER_SIGNED_EN.
module tb_mult_sequencer;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic       start = 1'b0;
    logic       abort = 1'b0;
    logic       mbit = 1'b0;
    logic       busy, load, clr_acc, add_en, sub_en, shift_en, done;
    logic [2:0] count;
    logic [2:0] state;

    int n_vec = 0;
    int n_err = 0;

    logic [7:0] add_mask, sub_mask;
    int n_shift, n_done, n_load, done_at;
    logic onehot_ok, cnt_ok;

    mult_sequencer #(.WIDTH(8)) dut (
        .clk(clk), .rst(rst), .start(start), .abort(abort), .mbit(mbit),
        .busy(busy), .load(load), .clr_acc(clr_acc), .add_en(add_en),
        .sub_en(sub_en), .shift_en(shift_en), .done(done), .count(count),
        .state(state)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Pulse start across one rising edge; returns at the negedge of the LOAD cycle.
    task automatic start_op();
        @(negedge clk);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
    endtask

    // Observe ncyc cycles from the current negedge, feeding mult LSB-first on mbit.
    task automatic watch(input logic [7:0] mult, input int ncyc, input int repulse_at);
        int iter;
        int hot;
        iter = 0;
        add_mask = '0; sub_mask = '0;
        n_shift = 0; n_done = 0; n_load = 0; done_at = -1;
        onehot_ok = 1'b1; cnt_ok = 1'b1;
        for (int n = 0; n < ncyc; n++) begin
            start = (n == repulse_at);
            mbit = (state == 3'b010 && iter < 8) ? mult[iter] : 1'b0;
            #1;
            hot = int'(add_en) + int'(sub_en) + int'(shift_en) + int'(load);
            if (hot > 1) onehot_ok = 1'b0;
            if (state == 3'b010 && count != 3'(iter)) cnt_ok = 1'b0;
            if (add_en && iter < 8) add_mask[iter] = 1'b1;
            if (sub_en && iter < 8) sub_mask[iter] = 1'b1;
            if (load) n_load++;
            if (shift_en) begin
                n_shift++;
                iter++;
            end
            if (done) begin
                n_done++;
                if (done_at < 0) done_at = n;
            end
            @(negedge clk);
        end
        start = 1'b0;
        mbit = 1'b0;
    endtask

    task automatic run_mult(input string tag, input logic [7:0] mult,
                            input logic [7:0] exp_add, input logic [7:0] exp_sub);
        start_op();
        watch(mult, 22, -1);
        check({tag, "_add"}, add_mask, exp_add);
        check({tag, "_sub"}, sub_mask, exp_sub);
        check({tag, "_shifts"}, n_shift, 8);
        check({tag, "_dones"}, n_done, 1);
        check({tag, "_latency"}, done_at, 17);
        check({tag, "_exclusive"}, onehot_ok, 1'b1);
        check({tag, "_count"}, cnt_ok, 1'b1);
        check({tag, "_idle"}, state, 3'b000);
    endtask

    initial begin
        int guard;
        // Reset state, held over a couple of edges
        repeat (2) @(negedge clk);
        check("rst_state", state, 3'b000);
        check("rst_outs", {busy, load, clr_acc, add_en, sub_en, shift_en, done}, 7'b0);
        check("rst_count", count, 3'd0);
        rst = 1'b1;

`ifdef MULT_SEQUENCER_SIGNED_EN
        run_mult("a5", 8'hA5, 8'h25, 8'h80);
        run_mult("ff", 8'hFF, 8'h7F, 8'h80);
`else
        run_mult("a5", 8'hA5, 8'hA5, 8'h00);
        run_mult("ff", 8'hFF, 8'hFF, 8'h00);
`endif
        run_mult("00", 8'h00, 8'h00, 8'h00);
        run_mult("3c", 8'h3C, 8'h3C, 8'h00);

        // Abort in EVAL at count 3
        start_op();
        guard = 0;
        while (!(state == 3'b010 && count == 3'd3) && guard < 20) begin
            @(negedge clk);
            guard++;
        end
        check("abort_reach", guard < 20, 1'b1);
        abort = 1'b1;
        @(negedge clk);
        abort = 1'b0;
        check("abort_state", state, 3'b000);
        check("abort_count", count, 3'd0);
        check("abort_busy", busy, 1'b0);
        watch(8'h00, 25, -1);
        check("abort_nodone", n_done, 0);

        // Abort and start together in IDLE
        @(negedge clk);
        start = 1'b1; abort = 1'b1;
        @(negedge clk);
        start = 1'b0; abort = 1'b0;
        check("absta_state", state, 3'b000);
        check("absta_busy", busy, 1'b0);

        // Start re-pulsed during EVAL at count 4 (cycle 9 after start)
        start_op();
        watch(8'h00, 24, 9);
        check("repulse_dones", n_done, 1);
        check("repulse_loads", n_load, 1);
        check("repulse_latency", done_at, 17);

        // Start held high: DONE, one IDLE cycle, then LOAD
        @(negedge clk);
        start = 1'b1;
        for (int n = 0; n < 20; n++) begin
            @(negedge clk);
            if (n == 17) check("held_done", state, 3'b100);
            if (n == 18) check("held_idle", state, 3'b000);
            if (n == 19) check("held_load", state, 3'b001);
        end
        start = 1'b0;
        abort = 1'b1;
        @(negedge clk);
        abort = 1'b0;
        check("held_abort", state, 3'b000);

        // Asynchronous reset during SHIFT, away from any edge
        start_op();
        guard = 0;
        while (state != 3'b011 && guard < 10) begin
            @(negedge clk);
            guard++;
        end
        check("rstmid_reach", guard < 10, 1'b1);
        #2;
        rst = 1'b0;
        #1;
        check("rstmid_state", state, 3'b000);
        check("rstmid_outs", {busy, load, clr_acc, add_en, sub_en, shift_en, done}, 7'b0);
        check("rstmid_count", count, 3'd0);
        @(negedge clk);
        rst = 1'b1;
        check("rstmid_hold", state, 3'b000);
`ifdef MULT_SEQUENCER_SIGNED_EN
        run_mult("post_rst", 8'hA5, 8'h25, 8'h80);
`else
        run_mult("post_rst", 8'hA5, 8'hA5, 8'h00);
`endif

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
